// File: rtl/inst_loader.sv
// Streams machine-code words into a writable instruction memory through a registered write port.
// Optional XOR checksum of the accepted words is enabled with INST_LOADER_CHECKSUM_EN.
module inst_loader #(
  parameter int IW = 10,
  parameter int DW = 9
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic          InValid,
  input  logic [DW-1:0] InData,
  input  logic          InLast,
  output logic          InReady,
  output logic          WrEn,
  output logic [IW-1:0] WrAddr,
  output logic [DW-1:0] WrData,
  output logic [IW:0]   WordCount,
  output logic          Done,
  output logic          Overflow
`ifdef INST_LOADER_CHECKSUM_EN
  ,output logic [DW-1:0] Checksum
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [IW-1:0] PTR_MAX = {IW{1'b1}};

  logic [1:0]    state_q, state_d;
  logic          wren_q, wren_d;
  logic [IW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [IW:0]   cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          accept_s;
  logic [IW-1:0] ptr_s;

  // The count never reaches 2**IW while loading, so its low bits are the write pointer.
  assign ptr_s    = cnt_q[IW-1:0];
  assign InReady  = (state_q == ST_LOAD);
  assign accept_s = InValid & InReady;

  // Session sequencing and write-port next state.
  always_comb begin
    state_d = state_q;
    wren_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (Start) begin
          state_d = ST_LOAD;
          cnt_d   = {(IW+1){1'b0}};
          done_d  = 1'b0;
          ovf_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          wren_d = 1'b1;
          addr_d = ptr_s;
          data_d = InData;
          cnt_d  = cnt_q + {{IW{1'b0}}, 1'b1};
          if (InLast) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else if (ptr_s == PTR_MAX) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
            ovf_d   = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      wren_q  <= 1'b0;
      addr_q  <= {IW{1'b0}};
      data_q  <= {DW{1'b0}};
      cnt_q   <= {(IW+1){1'b0}};
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign WrEn      = wren_q;
  assign WrAddr    = addr_q;
  assign WrData    = data_q;
  assign WordCount = cnt_q;
  assign Done      = done_q;
  assign Overflow  = ovf_q;

`ifdef INST_LOADER_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;

  // Running XOR of the session's accepted words; Start begins a fresh sum.
  always_comb begin
    csum_d = csum_q;
    if (state_q != ST_LOAD && Start) begin
      csum_d = {DW{1'b0}};
    end else if (accept_s) begin
      csum_d = csum_q ^ InData;
    end else begin
      csum_d = csum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      csum_q <= {DW{1'b0}};
    end else begin
      csum_q <= csum_d;
    end
  end

  assign Checksum = csum_q;
`else
  // Checksum port and register are absent in this build.
`endif

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader (IW=2 so the memory-full boundary is reachable quickly).
module tb_inst_loader;
  localparam int IW    = 2;
  localparam int DW    = 9;
  localparam int DEPTH = 1 << IW;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          Start = 1'b0;
  logic          InValid = 1'b0;
  logic [DW-1:0] InData = '0;
  logic          InLast = 1'b0;
  logic          InReady, WrEn, Done, Overflow;
  logic [IW-1:0] WrAddr;
  logic [DW-1:0] WrData;
  logic [IW:0]   WordCount;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [DW-1:0] Checksum;
`endif

  inst_loader #(.IW(IW), .DW(DW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .InValid(InValid),
    .InData(InData), .InLast(InLast), .InReady(InReady), .WrEn(WrEn),
    .WrAddr(WrAddr), .WrData(WrData), .WordCount(WordCount), .Done(Done),
    .Overflow(Overflow)
`ifdef INST_LOADER_CHECKSUM_EN
    , .Checksum(Checksum)
`endif
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected writes: {address, data}
  logic [IW+DW-1:0] exp_q[$];

  // Reference model of a load session
  bit          m_active;
  int          m_count;
  bit          m_done, m_ovf;
  logic [DW-1:0] m_csum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding accepted word.
  always @(negedge Clk) begin
    if (WrEn === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: addr %0h data %0h with nothing pending at %0t", WrAddr, WrData, $time);
      end else begin
        logic [IW+DW-1:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(WrAddr), 32'(e[IW+DW-1:DW]));
        check("wr_data", 32'(WrData), 32'(e[DW-1:0]));
      end
    end
  end

  task automatic check_status();
    check("word_count", 32'(WordCount), 32'(m_count));
    check("done", 32'(Done), 32'(m_done));
    check("overflow", 32'(Overflow), 32'(m_ovf));
`ifdef INST_LOADER_CHECKSUM_EN
    check("checksum", 32'(Checksum), 32'(m_csum));
`endif
  endtask

  task automatic reset_dut(input int n);
    @(negedge Clk);
    Reset_n = 1'b0; Start = 1'b0; InValid = 1'b0; InLast = 1'b0;
    repeat (n) @(posedge Clk);
    #1;
    m_active = 0; m_count = 0; m_done = 0; m_ovf = 0; m_csum = '0;
    check("rst_inready", 32'(InReady), 32'd0);
    check("rst_wren", 32'(WrEn), 32'd0);
    check("rst_wraddr", 32'(WrAddr), 32'd0);
    check("rst_wrdata", 32'(WrData), 32'd0);
    check_status();
  endtask

  task automatic cycle(input bit st, input bit vld, input logic [DW-1:0] d, input bit lst);
    @(negedge Clk);
    Reset_n = 1'b1; Start = st; InValid = vld; InData = d; InLast = lst;
    check("in_ready", 32'(InReady), 32'(m_active));
    if (!m_active && st) begin
      m_active = 1; m_count = 0; m_done = 0; m_ovf = 0; m_csum = '0;
    end else if (m_active && vld) begin
      exp_q.push_back({IW'(m_count), d});
      m_csum ^= d;
      m_count++;
      if (lst) begin
        m_active = 0; m_done = 1;
      end else if (m_count == DEPTH) begin
        m_active = 0; m_done = 1; m_ovf = 1;
      end
    end
    @(posedge Clk);
    #1;
    check_status();
  endtask

  initial begin
    m_active = 0; m_count = 0; m_done = 0; m_ovf = 0; m_csum = '0;
    reset_dut(2);

    // Basic back-to-back 3-word load, then idle cycles
    cycle(1, 0, '0, 0);
    cycle(0, 1, 9'b011100000, 0);
    cycle(0, 1, 9'b010110000, 0);
    cycle(0, 1, 9'b010010001, 1);
    repeat (2) cycle(0, 1, 9'h1ff, 0);
    check("basic_done", 32'(Done), 32'd1);
    check("basic_count", 32'(WordCount), 32'd3);

    // Gapped stream
    cycle(1, 0, '0, 0);
    cycle(0, 1, 9'h0a5, 0);
    cycle(0, 0, 9'h1ff, 0);
    cycle(0, 0, 9'h1ff, 1);
    cycle(0, 1, 9'h15a, 0);
    cycle(0, 1, 9'h033, 1);
    cycle(0, 0, '0, 0);

    // Overflow: five words, none marked last
    cycle(1, 0, '0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 9'(9'h100 + i), 0);
    check("ovf_flag", 32'(Overflow), 32'd1);
    check("ovf_count", 32'(WordCount), 32'(DEPTH));

    // Reset after two accepts; later words ignored
    cycle(1, 0, '0, 0);
    cycle(0, 1, 9'h011, 0);
    cycle(0, 1, 9'h022, 0);
    reset_dut(1);
    repeat (3) cycle(0, 1, 9'h044, 0);

    // Restart after Done, with Start pulsed mid-load
    cycle(1, 0, '0, 0);
    cycle(0, 1, 9'h077, 1);
    cycle(1, 0, '0, 0);
    cycle(0, 1, 9'h0e1, 0);
    cycle(1, 1, 9'h0e2, 0);
    cycle(0, 1, 9'h0e3, 1);
    cycle(0, 0, '0, 0);

    // Randomized sessions
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        reset_dut(1);
      end else begin
        cycle(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
              DW'($urandom), ($urandom_range(0, 4) == 0));
      end
    end
    cycle(0, 0, '0, 0);
    @(negedge Clk);
    #1;
    check("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
